parity_serial_tx: RTL and testbench
===================================

Name: parity_serial_tx

Overview:
Serial transmitter that frames a parallel data word for the team's serial parity checker. Accepts a DATA_W-bit word on a start/ready handshake and shifts it out LSB first on a one-bit line, one bit per clock. It then appends one parity bit, so the checker sees a stream whose parity is fixed. Sits between a parallel producer and the checker's serial input x.

Parameters:
DATA_W, 8, data bits per frame (>= 2)
ODD_PARITY, 0, 0 = even parity (data plus parity bit holds an even count of ones); 1 = odd parity

Ports:
clk  input  1  rising-edge system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to send din; accepted only when ready=1
din  input  DATA_W  word to send; sampled only on the accept cycle
ready  output  1  block can accept start this cycle
x  output  1  serial line to the checker; 0 when no bit is being driven
valid  output  1  x carries a frame bit (data or parity) this cycle
is_par  output  1  current x bit is the parity bit
done  output  1  one-cycle pulse, concurrent with the parity bit

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): state=IDLE, x=0, valid=0, is_par=0, done=0, ready=1. Shift register, bit counter and parity accumulator are cleared.
- Reset asserted mid-frame aborts the frame immediately. No partial parity bit is sent. After release, the block sits in IDLE.
- Accept: start=1 and ready=1 on a rising edge.
  - Load din into the shift register.
  - Set bit counter to 0.
  - Initialise the parity accumulator to ODD_PARITY.
- FSM states: IDLE, DATA, PARITY.
  - IDLE: x=0, valid=0. On accept, go to DATA.
  - DATA: x = shreg[0], valid=1. Each cycle:
    - accumulator ^= shreg[0]
    - shift right
    - counter += 1
    - after DATA_W bits, go to PARITY.
  - PARITY: x = accumulator (^din XOR ODD_PARITY), valid=1, is_par=1, done=1.
    - On accept, go to DATA with the new word (back-to-back, zero gap).
    - Otherwise go to IDLE.
- ready = (state==IDLE) or (state==PARITY).
- Start while in DATA is ignored; the din change has no effect on the frame in flight.
- Latency: accept edge -> bit 0 on x in the following cycle. Frame length is DATA_W+1 cycles.
- Outputs x, valid, is_par and done are registered (no combinational path from start/din).
- Counter width is clog2(DATA_W+1). It must not wrap inside a frame.
- The parity bit is computed serially from the bits actually sent, so it equals the reduction XOR of the accepted din.
- start=1 held continuously: frames stream back-to-back, each frame exactly DATA_W+1 valid cycles.

Test Plan:
- Even parity, din=8'hA5, one-cycle start -> x over next 9 cycles = 1,0,1,0,0,1,0,1,0. valid=1 all 9 cycles; is_par and done only on cycle 9; ready=0 cycles 1-8.
- Even parity, din=8'h07 -> x = 1,1,1,0,0,0,0,0, parity bit 1. Then IDLE with x=0, valid=0.
- ODD_PARITY=1, din=8'hA5 -> parity bit 1. din=8'h00 -> 8 zeros then parity bit 1.
- Back-to-back: start held high with din=8'hFF then 8'h01 -> 18 consecutive valid cycles. Parity bits 0 then 1; no idle gap; done pulses on cycles 9 and 18.
- Start and din=8'h00 asserted during cycle 4 of an 8'hA5 frame -> ignored; the A5 frame completes unchanged, then IDLE.
- rst_n pulled low at cycle 5 of a frame -> x=0, valid=0, done=0, ready=1 immediately. After release, a new start with 8'h3C sends 0,0,1,1,1,1,0,0,0 correctly.

Source files
------------

// File: rtl/parity_serial_tx.sv
// Serial parity framer: shifts a DATA_W-bit word out LSB first, then one parity bit.
// Outputs are flopped from next-state values, so there is no combinational path from start or din.
module parity_serial_tx #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              x,
    output logic              valid,
    output logic              is_par,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [DATA_W-1:0] r_shreg, w_shreg_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              r_acc, w_acc_next;
    logic              r_x, w_x_next;
    logic              r_valid, w_valid_next;
    logic              r_is_par, w_is_par_next;
    logic              r_done, w_done_next;
    logic              r_ready, w_ready_next;
    logic              w_accept;

    assign w_accept = start & r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_acc    <= 1'b0;
            r_x      <= 1'b0;
            r_valid  <= 1'b0;
            r_is_par <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_shreg  <= w_shreg_next;
            r_cnt    <= w_cnt_next;
            r_acc    <= w_acc_next;
            r_x      <= w_x_next;
            r_valid  <= w_valid_next;
            r_is_par <= w_is_par_next;
            r_done   <= w_done_next;
            r_ready  <= w_ready_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shreg_next = r_shreg;
        w_cnt_next   = r_cnt;
        w_acc_next   = r_acc;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = DATA;
                    w_shreg_next = din;
                    w_cnt_next   = '0;
                    w_acc_next   = ODD_PARITY;
                end
            end
            DATA: begin
                // Parity is folded in from the bit on the line, so it always matches what was sent.
                w_acc_next   = r_acc ^ r_shreg[0];
                w_shreg_next = r_shreg >> 1;
                w_cnt_next   = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_state_next = PARITY;
                end
            end
            PARITY: begin
                if (w_accept) begin
                    w_state_next = DATA;
                    w_shreg_next = din;
                    w_cnt_next   = '0;
                    w_acc_next   = ODD_PARITY;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output flops take what the next state will present, keeping bit 0 one cycle after accept.
    always_comb begin
        w_x_next      = 1'b0;
        w_valid_next  = 1'b0;
        w_is_par_next = 1'b0;
        w_done_next   = 1'b0;
        w_ready_next  = (w_state_next != DATA);

        case (w_state_next)
            DATA: begin
                w_x_next     = w_shreg_next[0];
                w_valid_next = 1'b1;
            end
            PARITY: begin
                w_x_next      = w_acc_next;
                w_valid_next  = 1'b1;
                w_is_par_next = 1'b1;
                w_done_next   = 1'b1;
            end
            default: begin
                w_x_next = 1'b0;
            end
        endcase
    end

    assign x      = r_x;
    assign valid  = r_valid;
    assign is_par = r_is_par;
    assign done   = r_done;
    assign ready  = r_ready;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: an even-parity and an odd-parity instance share one stimulus.
module tb_parity_serial_tx;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] din;

    logic e_ready, e_x, e_valid, e_is_par, e_done;
    logic o_ready, o_x, o_valid, o_is_par, o_done;

    int n_checks;
    int n_pass;

    parity_serial_tx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut_even (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .din    (din),
        .ready  (e_ready),
        .x      (e_x),
        .valid  (e_valid),
        .is_par (e_is_par),
        .done   (e_done)
    );

    parity_serial_tx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_odd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .din    (din),
        .ready  (o_ready),
        .x      (o_x),
        .valid  (o_valid),
        .is_par (o_is_par),
        .done   (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a word with start for one edge; returns just after the accept edge.
    task automatic start_frame(input logic [7:0] d);
        start = 1'b1;
        din   = d;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Sample ncyc frame cycles at mid-cycle; pe/po are the hand-computed even/odd parity bits.
    // inj > 0 pulses start with din=00 during that frame cycle.
    task automatic observe(input string name, input logic [7:0] d, input logic pe,
                           input logic po, input int inj, input int ncyc);
        logic ex_e, ex_o;
        for (int c = 1; c <= ncyc; c++) begin
            if (inj != 0 && c == inj) begin
                start = 1'b1;
                din   = 8'h00;
            end
            if (inj != 0 && c == inj + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            ex_e = (c <= 8) ? d[c-1] : pe;
            ex_o = (c <= 8) ? d[c-1] : po;
            check($sformatf("%s even x c%0d", name, c), 32'(e_x), 32'(ex_e));
            check($sformatf("%s odd x c%0d", name, c), 32'(o_x), 32'(ex_o));
            check($sformatf("%s valid c%0d", name, c), 32'(e_valid), 32'd1);
            check($sformatf("%s is_par c%0d", name, c), 32'(e_is_par), 32'(c == 9));
            check($sformatf("%s done c%0d", name, c), 32'(e_done), 32'(c == 9));
            check($sformatf("%s ready c%0d", name, c), 32'(e_ready), 32'(c == 9));
            check($sformatf("%s odd done c%0d", name, c), 32'(o_done), 32'(c == 9));
            if (c < ncyc) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(posedge clk);
        @(negedge clk);
        check({name, " idle x"},      32'(e_x),      32'd0);
        check({name, " idle valid"},  32'(e_valid),  32'd0);
        check({name, " idle is_par"}, 32'(e_is_par), 32'd0);
        check({name, " idle done"},   32'(e_done),   32'd0);
        check({name, " idle ready"},  32'(e_ready),  32'd1);
        check({name, " idle odd x"},  32'(o_x),      32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        start    = 1'b0;
        din      = 8'h00;
        rst_n    = 1'b1;
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst x",      32'(e_x),      32'd0);
        check("rst valid",  32'(e_valid),  32'd0);
        check("rst is_par", 32'(e_is_par), 32'd0);
        check("rst done",   32'(e_done),   32'd0);
        check("rst ready",  32'(e_ready),  32'd1);
        check("rst odd ready", 32'(o_ready), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // A5: 1,0,1,0,0,1,0,1 then parity even 0 / odd 1
        start_frame(8'hA5);
        observe("A5", 8'hA5, 1'b0, 1'b1, 0, 9);
        check_idle("A5");

        // 07: 1,1,1,0,0,0,0,0 then parity even 1 / odd 0
        start_frame(8'h07);
        observe("07", 8'h07, 1'b1, 1'b0, 0, 9);
        check_idle("07");

        // 00: eight zeros then parity even 0 / odd 1
        start_frame(8'h00);
        observe("00", 8'h00, 1'b0, 1'b1, 0, 9);
        check_idle("00");

        // Back-to-back FF then 01 with start held high: 18 valid cycles, no gap
        start = 1'b1;
        din   = 8'hFF;
        @(posedge clk);
        #1;
        din = 8'h01;
        observe("FF", 8'hFF, 1'b0, 1'b1, 0, 9);
        @(posedge clk);
        #1;
        start = 1'b0;
        observe("01", 8'h01, 1'b1, 1'b0, 0, 9);
        check_idle("01");

        // Start with din=00 during cycle 4 of an A5 frame is ignored
        start_frame(8'hA5);
        observe("A5ign", 8'hA5, 1'b0, 1'b1, 4, 9);
        check_idle("A5ign");

        // Reset at cycle 5 of a frame aborts it immediately
        start_frame(8'hA5);
        observe("A5rst", 8'hA5, 1'b0, 1'b1, 0, 4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst x",     32'(e_x),     32'd0);
        check("midrst valid", 32'(e_valid), 32'd0);
        check("midrst done",  32'(e_done),  32'd0);
        check("midrst ready", 32'(e_ready), 32'd1);
        check("midrst odd valid", 32'(o_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        check_idle("postrst");

        // 3C: 0,0,1,1,1,1,0,0 then parity even 0 / odd 1
        start_frame(8'h3C);
        observe("3C", 8'h3C, 1'b0, 1'b1, 0, 9);
        check_idle("3C");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
